// File: rtl/exp_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : exp_datapath_if
// Description : Strobe/operand bundle between the e^x series controller and
//               its datapath; the controller drives, the datapath answers.
// Revision    : 1.0  initial release
// ============================================================================
interface exp_datapath_if;
    logic [7:0]  x_in;
    logic        ldx;
    logic        ldy;
    logic        ldr;
    logic        ldt;
    logic        ldadr;
    logic        initr;
    logic        initt;
    logic        zadr;
    logic        xmult;
    logic        coeffmult;
    logic        gt;
    logic [15:0] y_out;

    modport master (
        output x_in, ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult,
        input  gt, y_out
    );

    modport slave (
        input  x_in, ldx, ldy, ldr, ldt, ldadr, initr, initt, zadr, xmult, coeffmult,
        output gt, y_out
    );
endinterface
`default_nettype wire

// File: rtl/exp_datapath.sv
`default_nettype none
// ============================================================================
// Module      : exp_datapath
// Description : Taylor-series e^x datapath: operand, term, partial sum,
//               coefficient address and result registers plus 1/(k+1) ROM.
// Revision    : 1.0  initial release
// ============================================================================
module exp_datapath #(
    parameter int N_TERMS = 8
) (
    input  wire            clk,
    input  wire            rst,
    exp_datapath_if.slave  dp
);

    localparam int        c_ROM_DEPTH = 16;
    localparam logic [15:0] c_ONE_Q2_14 = 16'h4000;
    localparam logic [3:0]  c_ADR_MAX   = 4'd15;

    logic [7:0]  r_x;
    logic [15:0] r_t;
    logic [15:0] r_r;
    logic [3:0]  r_adr;
    logic [15:0] r_y;

    logic [15:0] w_rom [0:c_ROM_DEPTH-1];
    logic [15:0] w_coeff;
    logic [15:0] w_mul_op;
    logic [31:0] w_prod;
    logic [15:0] w_mul_res;
    logic        w_mul_en;
    logic [16:0] w_sum;
    logic [15:0] w_r_sat;
    logic        w_gt;
    logic        w_unused;

    // Entries past N_TERMS read as zero so a runaway address kills the term.
    for (genvar gi = 0; gi < c_ROM_DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = (gi < N_TERMS) ? 16'(32768 / (gi + 1)) : 16'd0;
    end

    assign w_coeff  = w_rom[r_adr];
    assign w_mul_op = dp.xmult ? {8'd0, r_x} : w_coeff;
    assign w_prod   = r_t * w_mul_op;
    assign w_mul_en = dp.xmult | dp.coeffmult;

    // Q2.14 * Q0.8 keeps bits [23:8]; Q2.14 * Q1.15 keeps bits [30:15].
    assign w_mul_res = dp.xmult ? w_prod[23:8] : w_prod[30:15];
    assign w_unused  = &{1'b0, w_prod[31], w_prod[7:0]};

    assign w_sum   = {1'b0, r_r} + {1'b0, r_t};
    assign w_r_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    assign w_gt = ({1'b0, r_adr} >= 5'(N_TERMS));

    assign dp.gt    = w_gt;
    assign dp.y_out = r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= 8'd0;
        end else if (dp.ldx) begin
            r_x <= dp.x_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t <= 16'd0;
        end else if (dp.initt) begin
            r_t <= c_ONE_Q2_14;
        end else if (dp.ldt && w_mul_en) begin
            r_t <= w_mul_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_r <= 16'd0;
        end else if (dp.initr) begin
            r_r <= 16'd0;
        end else if (dp.ldr) begin
            r_r <= w_r_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adr <= 4'd0;
        end else if (dp.zadr) begin
            r_adr <= 4'd0;
        end else if (dp.ldadr && (r_adr != c_ADR_MAX)) begin
            r_adr <= r_adr + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y <= 16'd0;
        end else if (dp.ldy) begin
            r_y <= r_r;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_datapath
// Description : Directed vector table plus hand sequences for exp_datapath.
// Revision    : 1.0  initial release
// ============================================================================
module tb_exp_datapath;

    localparam int N_TERMS = 8;

    localparam logic [9:0] S_LDX   = 10'd1;
    localparam logic [9:0] S_LDY   = 10'd2;
    localparam logic [9:0] S_LDR   = 10'd4;
    localparam logic [9:0] S_LDT   = 10'd8;
    localparam logic [9:0] S_LDADR = 10'd16;
    localparam logic [9:0] S_INITR = 10'd32;
    localparam logic [9:0] S_INITT = 10'd64;
    localparam logic [9:0] S_ZADR  = 10'd128;
    localparam logic [9:0] S_XMUL  = 10'd256;
    localparam logic [9:0] S_CMUL  = 10'd512;

    typedef struct {
        string       name;
        logic [9:0]  stb;
        logic [7:0]  x;
        logic [7:0]  ex;
        logic [15:0] et;
        logic [15:0] er;
        logic [3:0]  ea;
        logic [15:0] ey;
        logic        eg;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    exp_datapath_if dp ();

    exp_datapath #(.N_TERMS(N_TERMS)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] s, input logic [7:0] x);
        dp.ldx       = s[0];
        dp.ldy       = s[1];
        dp.ldr       = s[2];
        dp.ldt       = s[3];
        dp.ldadr     = s[4];
        dp.initr     = s[5];
        dp.initt     = s[6];
        dp.zadr      = s[7];
        dp.xmult     = s[8];
        dp.coeffmult = s[9];
        dp.x_in      = x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_win(input string nm, input logic [15:0] act, input int centre, input int tol);
        n_tests++;
        if ((int'(act) < centre - tol) || (int'(act) > centre + tol)) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", nm, act, centre, tol);
        end
    endtask

    task automatic chk_zero_state(input string nm);
        chk({nm, "_x"},   32'(dut.r_x),   32'd0);
        chk({nm, "_t"},   32'(dut.r_t),   32'd0);
        chk({nm, "_r"},   32'(dut.r_r),   32'd0);
        chk({nm, "_adr"}, 32'(dut.r_adr), 32'd0);
        chk({nm, "_y"},   32'(dp.y_out),  32'd0);
        chk({nm, "_gt"},  32'(dp.gt),     32'd0);
    endtask

    // Reference: series with truncation after each multiply, saturating sum.
    function automatic logic [15:0] model_exp(input logic [7:0] x);
        logic [31:0] t;
        logic [31:0] r;
        logic [31:0] c;
        t = 32'h4000;
        r = 32'd0;
        for (int k = 0; k < N_TERMS; k++) begin
            r = (r + t > 32'hFFFF) ? 32'hFFFF : r + t;
            t = (t * 32'(x)) >> 8;
            c = 32'd32768 / 32'(k + 1);
            t = ((t * c) >> 15) & 32'hFFFF;
        end
        r = (r + t > 32'hFFFF) ? 32'hFFFF : r + t;
        return r[15:0];
    endfunction

    task automatic run_exp(input logic [7:0] x, input string nm, output logic [15:0] y);
        drive(S_LDX | S_INITR | S_INITT | S_ZADR, x);
        step();
        for (int k = 0; k < N_TERMS; k++) begin
            drive(S_LDR, 8'h00);         step();
            drive(S_LDT | S_XMUL, 8'h00); step();
            drive(S_LDT | S_CMUL, 8'h00); step();
            drive(S_LDADR, 8'h00);       step();
            chk($sformatf("%s_gt_k%0d", nm, k + 1), 32'(dp.gt), 32'((k + 1) >= N_TERMS));
        end
        drive(S_LDR, 8'h00); step();
        drive(S_LDY, 8'h00); step();
        drive(10'd0, 8'h00);
        y = dp.y_out;
        chk({nm, "_exact"}, 32'(y), 32'(model_exp(x)));
        step();
        chk({nm, "_hold"}, 32'(dp.y_out), 32'(y));
    endtask

    vec_t        vecs [16];
    logic [15:0] y;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        drive(10'd0, 8'h00);

        // Held reset with toggling strobes must leave everything cleared.
        for (int i = 0; i < 10; i++) begin
            drive(10'($urandom), 8'($urandom));
            step();
            chk_zero_state($sformatf("rst_hold%0d", i));
        end
        drive(10'd0, 8'h00);
        rst = 1'b1;
        step();

        vecs[0]  = '{"ldx",         S_LDX,                  8'h80, 8'h80, 16'h0000, 16'h0000, 4'd0, 16'h0000, 1'b0};
        vecs[1]  = '{"init_tr",     S_INITT | S_INITR,      8'h33, 8'h80, 16'h4000, 16'h0000, 4'd0, 16'h0000, 1'b0};
        vecs[2]  = '{"ldr",         S_LDR,                  8'h33, 8'h80, 16'h4000, 16'h4000, 4'd0, 16'h0000, 1'b0};
        vecs[3]  = '{"initt_pri",   S_INITT|S_LDT|S_XMUL,   8'h33, 8'h80, 16'h4000, 16'h4000, 4'd0, 16'h0000, 1'b0};
        vecs[4]  = '{"initr_pri",   S_INITR | S_LDR,        8'h33, 8'h80, 16'h4000, 16'h0000, 4'd0, 16'h0000, 1'b0};
        vecs[5]  = '{"ldr_old_t",   S_LDR|S_LDT|S_XMUL,     8'h33, 8'h80, 16'h2000, 16'h4000, 4'd0, 16'h0000, 1'b0};
        vecs[6]  = '{"ldadr1",      S_LDADR,                8'h33, 8'h80, 16'h2000, 16'h4000, 4'd1, 16'h0000, 1'b0};
        vecs[7]  = '{"ldadr2",      S_LDADR,                8'h33, 8'h80, 16'h2000, 16'h4000, 4'd2, 16'h0000, 1'b0};
        vecs[8]  = '{"zadr_pri",    S_ZADR | S_LDADR,       8'h33, 8'h80, 16'h2000, 16'h4000, 4'd0, 16'h0000, 1'b0};
        vecs[9]  = '{"xmul_pri",    S_LDT|S_XMUL|S_CMUL,    8'h33, 8'h80, 16'h1000, 16'h4000, 4'd0, 16'h0000, 1'b0};
        vecs[10] = '{"ldadr_a",     S_LDADR,                8'h33, 8'h80, 16'h1000, 16'h4000, 4'd1, 16'h0000, 1'b0};
        vecs[11] = '{"ldadr_b",     S_LDADR,                8'h33, 8'h80, 16'h1000, 16'h4000, 4'd2, 16'h0000, 1'b0};
        vecs[12] = '{"coef_mul",    S_LDT | S_CMUL,         8'h33, 8'h80, 16'h0555, 16'h4000, 4'd2, 16'h0000, 1'b0};
        vecs[13] = '{"ldt_nomul",   S_LDT,                  8'h33, 8'h80, 16'h0555, 16'h4000, 4'd2, 16'h0000, 1'b0};
        vecs[14] = '{"ldx_ldy",     S_LDX | S_LDY,          8'hFF, 8'hFF, 16'h0555, 16'h4000, 4'd2, 16'h4000, 1'b0};
        vecs[15] = '{"xmul_ff",     S_LDT | S_XMUL,         8'h33, 8'hFF, 16'h054F, 16'h4000, 4'd2, 16'h4000, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stb, vecs[i].x);
            step();
            chk({vecs[i].name, "_x"},   32'(dut.r_x),   32'(vecs[i].ex));
            chk({vecs[i].name, "_t"},   32'(dut.r_t),   32'(vecs[i].et));
            chk({vecs[i].name, "_r"},   32'(dut.r_r),   32'(vecs[i].er));
            chk({vecs[i].name, "_adr"}, 32'(dut.r_adr), 32'(vecs[i].ea));
            chk({vecs[i].name, "_y"},   32'(dp.y_out),  32'(vecs[i].ey));
            chk({vecs[i].name, "_gt"},  32'(dp.gt),     32'(vecs[i].eg));
        end

        run_exp(8'h00, "exp_x00", y);
        chk("exp_x00_one", 32'(y), 32'h4000);
        run_exp(8'h80, "exp_x80", y);
        chk_win("exp_x80_win", y, 16'h6984, 8);
        run_exp(8'hFF, "exp_xFF", y);
        // e^(255/256) in Q2.14 is about 0xAD4A.
        chk_win("exp_xFF_win", y, 16'hAD4A, 32);

        // Partial-sum saturation and address saturation.
        drive(S_INITR | S_INITT | S_ZADR, 8'h00);
        step();
        begin
            logic [15:0] sat_exp [5];
            sat_exp = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hFFFF};
            for (int i = 0; i < 5; i++) begin
                drive(S_LDR, 8'h00);
                step();
                chk($sformatf("rsat%0d", i), 32'(dut.r_r), 32'(sat_exp[i]));
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive(S_LDADR, 8'h00);
            step();
            chk($sformatf("adrsat%0d", i), 32'(dut.r_adr), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("gtsat%0d", i), 32'(dp.gt), 32'((i + 1) >= N_TERMS));
        end

        // Asynchronous reset between clock edges in the middle of a loop.
        drive(S_LDX | S_INITR | S_INITT | S_ZADR, 8'hC0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(S_LDR, 8'h00);         step();
            drive(S_LDT | S_XMUL, 8'h00); step();
            drive(S_LDT | S_CMUL, 8'h00); step();
            drive(S_LDADR, 8'h00);       step();
        end
        drive(S_LDR, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk_zero_state("async_rst");
        step();
        drive(10'd0, 8'h00);
        rst = 1'b1;
        step();
        chk_zero_state("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
